// File: rtl/novena_bus_pkg.sv
// Shared decode constants for the EIM-side bus target: window codes,
// register offsets and CMD/STATUS bit positions.
package novena_bus_pkg;

    localparam logic [2:0] WIN_REG    = 3'd0;
    localparam logic [2:0] WIN_STREAM = 3'd1;

    localparam logic [3:0] REG_ID       = 4'd0;
    localparam logic [3:0] REG_SCRATCH  = 4'd1;
    localparam logic [3:0] REG_CTRL     = 4'd2;
    localparam logic [3:0] REG_CMD      = 4'd3;
    localparam logic [3:0] REG_TX_LEVEL = 4'd4;
    localparam logic [3:0] REG_RX_LEVEL = 4'd5;
    localparam logic [3:0] REG_STATUS   = 4'd6;

    localparam int CMD_FLUSH_TX   = 0;
    localparam int CMD_FLUSH_RX   = 1;
    localparam int CMD_CLR_STICKY = 2;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_FULL      = 2;
    localparam int ST_RX_EMPTY     = 3;
    localparam int ST_TX_OVERFLOW  = 4;
    localparam int ST_RX_UNDERFLOW = 5;

    function automatic logic [15:0] pack_status(
        input logic tx_full,
        input logic tx_empty,
        input logic rx_full,
        input logic rx_empty,
        input logic tx_ovf,
        input logic rx_udf
    );
        logic [15:0] word;
        word                  = 16'h0000;
        word[ST_TX_FULL]      = tx_full;
        word[ST_TX_EMPTY]     = tx_empty;
        word[ST_RX_FULL]      = rx_full;
        word[ST_RX_EMPTY]     = rx_empty;
        word[ST_TX_OVERFLOW]  = tx_ovf;
        word[ST_RX_UNDERFLOW] = rx_udf;
        return word;
    endfunction

endpackage

// File: rtl/novena_sync_fifo.sv
// Show-ahead synchronous FIFO with synchronous flush; pointers carry one
// extra bit so a full FIFO holds exactly 2**AW words.
module novena_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    logic [DATA_W-1:0] mem_r [0:(1<<AW)-1];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              pop_ok_s;
    logic              push_ok_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level     = wr_ptr_r - rd_ptr_r;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];
    assign pop_ok_s  = pop && !empty;
    // A pop in the same cycle frees the slot a push at full needs.
    assign push_ok_s = push && (!full || pop_ok_s);

    // Pointer update; flush discards any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            else           rd_ptr_r <= rd_ptr_r;
        end
    end

    // Storage array, kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/novena_bus_target.sv
// EIM-side bus responder: register window plus a streaming window bridging
// CPU reads/writes onto the RX/TX sample FIFOs.
module novena_bus_target
    import novena_bus_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                FIFO_AW  = 9,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'h4E52
) (
    input  logic              bus_clk,
    input  logic              reset_n,
    input  logic [18:0]       bus_addr,
    input  logic              bus_sel,
    input  logic              bus_wr,
    input  logic [DATA_W-1:0] bus_data_wr,
    output logic [DATA_W-1:0] bus_data_rd,
    output logic              bus_rdy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] ctrl_out
);

    logic              reg_win_s, stream_win_s, wr_cyc_s, rd_cyc_s, cmd_wr_s;
    logic [3:0]        reg_off_s;
    logic              addr_unused_s;
    logic              tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [FIFO_AW:0]  tx_level_s, rx_level_s;
    logic [DATA_W-1:0] rx_head_s, rd_data_s, tx_lvl_ext_s, rx_lvl_ext_s;
    logic              tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic              tx_flush_s, rx_flush_s, sticky_clr_s;
    logic              tx_ovf_set_s, rx_udf_set_s;
    logic [DATA_W-1:0] scratch_r, ctrl_r, bus_data_rd_r;
    logic              tx_ovf_r, rx_udf_r;

    assign reg_win_s     = (bus_addr[18:16] == WIN_REG);
    assign stream_win_s  = (bus_addr[18:16] == WIN_STREAM);
    assign reg_off_s     = bus_addr[3:0];
    assign addr_unused_s = ^bus_addr[15:4];
    assign wr_cyc_s      = bus_sel && bus_wr;
    assign rd_cyc_s      = bus_sel && !bus_wr;
    assign cmd_wr_s      = wr_cyc_s && reg_win_s && (reg_off_s == REG_CMD);
    assign tx_flush_s    = cmd_wr_s && bus_data_wr[CMD_FLUSH_TX];
    assign rx_flush_s    = cmd_wr_s && bus_data_wr[CMD_FLUSH_RX];
    assign sticky_clr_s  = cmd_wr_s && bus_data_wr[CMD_CLR_STICKY];

    assign tx_pop_s      = !tx_empty_s && tx_ready;
    assign tx_push_s     = wr_cyc_s && stream_win_s && (!tx_full_s || tx_pop_s);
    assign tx_ovf_set_s  = wr_cyc_s && stream_win_s && !tx_push_s;
    assign rx_push_s     = rx_valid && !rx_full_s;
    assign rx_pop_s      = rd_cyc_s && stream_win_s && !rx_empty_s;
    assign rx_udf_set_s  = rd_cyc_s && stream_win_s && rx_empty_s;

    assign tx_valid    = !tx_empty_s;
    assign rx_ready    = !rx_full_s;
    assign ctrl_out    = ctrl_r;
    assign bus_data_rd = bus_data_rd_r;
    // Advisory only: the bridge never stalls, so drops are still handled.
    assign bus_rdy     = !(stream_win_s && ((bus_wr && tx_full_s) || (!bus_wr && rx_empty_s)));

    novena_sync_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
        .clk(bus_clk), .rst_n(reset_n), .flush(tx_flush_s),
        .push(tx_push_s), .push_data(bus_data_wr), .pop(tx_pop_s),
        .head(tx_data), .full(tx_full_s), .empty(tx_empty_s), .level(tx_level_s)
    );

    novena_sync_fifo #(.DATA_W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
        .clk(bus_clk), .rst_n(reset_n), .flush(rx_flush_s),
        .push(rx_push_s), .push_data(rx_data), .pop(rx_pop_s),
        .head(rx_head_s), .full(rx_full_s), .empty(rx_empty_s), .level(rx_level_s)
    );

    // Read-data mux; reflects state before any same-cycle update.
    always_comb begin
        rd_data_s                   = {DATA_W{1'b0}};
        tx_lvl_ext_s                = {DATA_W{1'b0}};
        rx_lvl_ext_s                = {DATA_W{1'b0}};
        tx_lvl_ext_s[FIFO_AW:0]     = tx_level_s;
        rx_lvl_ext_s[FIFO_AW:0]     = rx_level_s;
        if (reg_win_s) begin
            case (reg_off_s)
                REG_ID:       rd_data_s = ID_VALUE;
                REG_SCRATCH:  rd_data_s = scratch_r;
                REG_CTRL:     rd_data_s = ctrl_r;
                REG_TX_LEVEL: rd_data_s = tx_lvl_ext_s;
                REG_RX_LEVEL: rd_data_s = rx_lvl_ext_s;
                REG_STATUS:   rd_data_s = pack_status(tx_full_s, tx_empty_s, rx_full_s,
                                                      rx_empty_s, tx_ovf_r, rx_udf_r);
                default:      rd_data_s = {DATA_W{1'b0}};
            endcase
        end else if (stream_win_s) begin
            if (!rx_empty_s) rd_data_s = rx_head_s;
            else             rd_data_s = {DATA_W{1'b0}};
        end else begin
            rd_data_s = {DATA_W{1'b0}};
        end
    end

    // Writable registers, sticky flags and the registered read port.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_r     <= {DATA_W{1'b0}};
            ctrl_r        <= {DATA_W{1'b0}};
            tx_ovf_r      <= 1'b0;
            rx_udf_r      <= 1'b0;
            bus_data_rd_r <= {DATA_W{1'b0}};
        end else begin
            if (wr_cyc_s && reg_win_s && (reg_off_s == REG_SCRATCH)) scratch_r <= bus_data_wr;
            if (wr_cyc_s && reg_win_s && (reg_off_s == REG_CTRL))    ctrl_r    <= bus_data_wr;
            if (sticky_clr_s)      tx_ovf_r <= 1'b0;
            else if (tx_ovf_set_s) tx_ovf_r <= 1'b1;
            if (sticky_clr_s)      rx_udf_r <= 1'b0;
            else if (rx_udf_set_s) rx_udf_r <= 1'b1;
            if (rd_cyc_s)          bus_data_rd_r <= rd_data_s;
        end
    end

endmodule

// File: tb/tb_novena_bus_target.sv
// Directed bench for novena_bus_target with queue-based scoreboards for bus
// read data, the TX stream and an RX FIFO occupancy model.
module tb_novena_bus_target;

    logic        bus_clk = 1'b0;
    logic        reset_n;
    logic [18:0] bus_addr;
    logic        bus_sel, bus_wr;
    logic [15:0] bus_data_wr, bus_data_rd;
    logic        bus_rdy;
    logic [15:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid, rx_ready;
    logic [15:0] ctrl_out;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] tx_q[$];
    logic [15:0] rx_model[$];
    bit          rx_pop_pend;
    int          n_checks;
    int          n_errors;

    always #5 bus_clk = ~bus_clk;

    novena_bus_target dut (
        .bus_clk(bus_clk), .reset_n(reset_n), .bus_addr(bus_addr), .bus_sel(bus_sel),
        .bus_wr(bus_wr), .bus_data_wr(bus_data_wr), .bus_data_rd(bus_data_rd),
        .bus_rdy(bus_rdy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .ctrl_out(ctrl_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the edge's handshakes, compare outputs at negedge.
    task automatic tick();
        logic        tx_fire, rx_fire, pend;
        logic [15:0] tx_word, rx_word, e;
        string       t;
        tx_fire = tx_valid && tx_ready && reset_n;
        tx_word = tx_data;
        rx_fire = rx_valid && reset_n && (rx_model.size() < 512);
        rx_word = rx_data;
        pend    = bus_sel && !bus_wr && reset_n;
        @(posedge bus_clk);
        if (rx_pop_pend) begin
            void'(rx_model.pop_front());
            rx_pop_pend = 1'b0;
        end
        if (rx_fire) rx_model.push_back(rx_word);
        @(negedge bus_clk);
        if (pend) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL rd_unexpected observed=%0h expected=none", bus_data_rd);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, bus_data_rd, e);
            end
        end
        if (tx_fire) begin
            n_checks++;
            assert (tx_q.size() > 0) else begin
                n_errors++;
                $error("FAIL tx_extra observed=%0h expected=none", tx_word);
            end
            if (tx_q.size() > 0) check("tx_data", tx_word, tx_q.pop_front());
        end
    endtask

    task automatic bus_write(input logic [18:0] addr, input logic [15:0] data);
        bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = addr; bus_data_wr = data;
        tick();
        bus_sel = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [18:0] addr, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = addr;
        tick();
        bus_sel = 1'b0;
    endtask

    task automatic stream_read(input logic [15:0] off);
        logic [15:0] e;
        if (rx_model.size() > 0) begin
            e = rx_model[0];
            rx_pop_pend = 1'b1;
        end else begin
            e = 16'h0000;
        end
        bus_read({3'd1, off}, e, "stream_rd");
    endtask

    initial begin
        n_checks = 0; n_errors = 0; rx_pop_pend = 1'b0;
        reset_n = 1'b0; bus_addr = 19'h0; bus_sel = 1'b0; bus_wr = 1'b0;
        bus_data_wr = 16'h0; tx_ready = 1'b0; rx_data = 16'h0; rx_valid = 1'b0;
        repeat (2) @(negedge bus_clk);
        check("rst_bus_data_rd", bus_data_rd, 16'h0000);
        check("rst_ctrl_out", ctrl_out, 16'h0000);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_bus_rdy", bus_rdy, 1'b1);
        reset_n = 1'b1;
        tick();

        // Register reads after reset
        bus_read(19'h00000, 16'h4E52, "id");
        bus_read(19'h00001, 16'h0000, "scratch_rst");
        bus_read(19'h00006, 16'h000A, "status_rst");

        // Scratch / ctrl
        bus_write(19'h00001, 16'hA5C3);
        bus_write(19'h00002, 16'h0101);
        check("ctrl_out", ctrl_out, 16'h0101);
        bus_read(19'h00001, 16'hA5C3, "scratch");
        bus_read(19'h00002, 16'h0101, "ctrl");
        bus_read(19'h00007, 16'h0000, "reg7");
        bus_read(19'h20000, 16'h0000, "win2");

        // TX overflow: 513 words with consumer stalled
        tx_ready = 1'b0;
        for (int i = 0; i <= 512; i++) begin
            if (i < 512) tx_q.push_back(16'(i));
            bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = {3'd1, 16'(i)}; bus_data_wr = 16'(i);
            #1;
            if (i == 0)   check("bus_rdy_tx_free", bus_rdy, 1'b1);
            if (i == 512) check("bus_rdy_tx_full", bus_rdy, 1'b0);
            tick();
        end
        bus_sel = 1'b0; bus_wr = 1'b0;
        bus_read(19'h00004, 16'h0200, "tx_level_full");
        bus_read(19'h00006, 16'h0019, "status_tx_full");
        tx_ready = 1'b1;
        for (int c = 0; c < 600 && tx_q.size() > 0; c++) tick();
        check("tx_drain_left", tx_q.size(), 0);
        check("tx_valid_drained", tx_valid, 1'b0);
        tick();
        tx_ready = 1'b0;

        // RX stream then burst read with underflow
        rx_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            rx_data = 16'(k);
            tick();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 5; i++) stream_read(16'(i));
        bus_addr = 19'h10005; bus_wr = 1'b0;
        #1;
        check("bus_rdy_rx_empty", bus_rdy, 1'b0);
        bus_read(19'h00006, 16'h003A, "status_sticky");
        bus_write(19'h00003, 16'h0004);
        bus_read(19'h00006, 16'h000A, "status_cleared");
        bus_read(19'h00003, 16'h0000, "cmd_reads_0");

        // TX flush racing a pop
        for (int i = 0; i < 3; i++) bus_write({3'd1, 16'(i)}, 16'h0100 + 16'(i));
        bus_read(19'h00004, 16'h0003, "tx_level_3");
        tx_q.push_back(16'h0100);
        tx_ready = 1'b1;
        bus_write(19'h00003, 16'h0001);
        check("tx_valid_flushed", tx_valid, 1'b0);
        repeat (3) tick();
        check("tx_q_left", tx_q.size(), 0);
        bus_read(19'h00004, 16'h0000, "tx_level_flushed");
        tx_ready = 1'b0;

        // RX full, reads with rx_valid held
        rx_valid = 1'b1;
        for (int k = 0; k < 512; k++) begin
            rx_data = 16'h1000 + 16'(k);
            tick();
        end
        rx_data = 16'h2000;
        check("rx_ready_full", rx_ready, 1'b0);
        bus_read(19'h00005, 16'h0200, "rx_level_full");
        for (int i = 0; i < 6; i++) begin
            rx_data = 16'h2001 + 16'(i);
            stream_read(16'(i));
        end
        check("rx_ready_reassert", rx_ready, 1'b1);
        rx_data = 16'h2100;
        bus_read(19'h00005, 16'(rx_model.size()), "rx_level_511");
        rx_data = 16'h2101;
        bus_read(19'h00005, 16'(rx_model.size()), "rx_level_512");

        // Reset in the middle of a read burst
        stream_read(16'h0000);
        stream_read(16'h0001);
        bus_sel = 1'b1; bus_wr = 1'b0; bus_addr = 19'h10002;
        reset_n = 1'b0;
        #1;
        check("midrst_bus_data_rd", bus_data_rd, 16'h0000);
        check("midrst_rx_ready", rx_ready, 1'b1);
        check("midrst_ctrl_out", ctrl_out, 16'h0000);
        rx_model.delete(); exp_q.delete(); tag_q.delete(); rx_pop_pend = 1'b0;
        rx_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        stream_read(16'h0003);
        stream_read(16'h0004);
        bus_read(19'h00005, 16'h0000, "rx_level_after_rst");
        bus_read(19'h00006, 16'h002A, "status_after_rst");
        bus_read(19'h00001, 16'h0000, "scratch_after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
